tlb_lookup: RTL
===============

# tlb_lookup

Pipelined translation/search port that reads the shared TLB entry array and turns a virtual address request into a physical address, memory type and exception code. It sits between the array, which has one write port and exposes every entry to lookups, and the fetch/LSU stages. One instance serves instruction fetch and one serves data access. It uses a two-stage valid/ready pipeline that accepts one request per cycle.

## Interface
- TLB_ENTRY_NUM, 16, number of entries compared in parallel.
- TLB_IDX_WID, 4, equal to $clog2(TLB_ENTRY_NUM).
- clk  in  1  clock; everything samples on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drops both in-flight stages this cycle.
- entries  in  tlb_entry_t[TLB_ENTRY_NUM]  live entry array.
- req_valid / req_ready  in / out  1  request handshake.
- req_va  in  32  virtual address.
- req_asid  in  10  current ASID.
- req_plv  in  2  current privilege level.
- req_op  in  tlb_op_t  FETCH / LOAD / STORE.
- resp_valid / resp_ready  out / in  1  response handshake.
- resp_pa  out  32  physical address.
- resp_mat  out  2  memory access type.
- resp_hit  out  1  an entry matched.
- resp_idx  out  TLB_IDX_WID  index of the matched entry.
- resp_excp  out  tlb_excp_t  NONE / TLBR / PIF / PIL / PIS / PPI / PME.
- resp_multi_hit  out  1  more than one entry matched; present only with the macro (see Configuration).

## Operation
- Entry i matches when all of these hold:
  - e is set.
  - g is set, or asid equals req_asid.
  - The VPN compares equal. For ps==12, vppn[18:0]==va[31:13]. For ps==21, vppn[18:9]==va[31:22].
- If several entries match, the lowest index wins.
- Stage 1, entered on req_valid && req_ready:
  - Registers va, plv and op.
  - Registers the one-hot hit vector, the encoded idx and a copy of the winning entry.
  - A write to the array after acceptance does not affect that request.
- Stage 2:
  - Page half: odd = (ps==21) ? va[21] : va[12]. Select the {ppn, plv, mat, d, v} fields of that half.
  - PA for ps==12: {ppn[19:0], va[11:0]}.
  - PA for ps==21: {ppn[19:9], va[20:0]}.
- Exception priority, first true wins:
  1. No hit gives TLBR.
  2. !v gives PIF, PIL or PIS according to op.
  3. req_plv > entry plv gives PPI.
  4. op==STORE && !d gives PME.
  5. Otherwise NONE.
- When resp_excp≠NONE, resp_pa and resp_mat are still driven from the selected fields. On a miss they are 0.
- No FSM. Control is two valid bits, s1_valid and s2_valid.

## Timing
- Latency: a request accepted at edge k has resp_valid high from edge k+2 (after k+1 for stage 1 and k+2 for stage 2). The response holds until resp_valid && resp_ready.
- Advance rules:
  - s2 loads when !s2_valid || resp_ready.
  - s1 advances under the same condition.
  - req_ready = !flush && (!s1_valid || s1 advances).
- Throughput is 1 per cycle when resp_ready is held high. Back-pressure stalls both stages with no loss and no duplication.
- Response outputs are registered and stable while resp_valid && !resp_ready.
- flush: s1_valid and s2_valid are 0 after the edge, a concurrent request is not accepted, and flush overrides a concurrent resp handshake.
- Reset: s1_valid=s2_valid=0, resp_valid=0, resp_pa=0, resp_mat=0, resp_hit=0, resp_idx=0, resp_excp=NONE, resp_multi_hit=0. The rst cycle behaves as flush.

## Configuration
- TLB_MULTI_HIT_CHECK_EN defined: stage 1 also registers whether more than one hit bit is set, and stage 2 drives it on resp_multi_hit. The lowest-index result is still returned.
- TLB_MULTI_HIT_CHECK_EN not defined: the port is absent and there is no popcount logic.

## Structure
- cpu_defs package holds:
  - tlb_entry_t, existing.
  - TLB_ENTRY_NUM and TLB_IDX_WID, existing.
  - New tlb_op_t, tlb_excp_t and a ps encoding constant.
- Sub-module tlb_match: combinational per-entry compare plus priority encoder, producing hit vector, idx and selected entry. It is reused for TLBSRCH.

## Test plan
- 4 KB page: entry 3 with vppn=0x00012, ps=12, asid=5, v0=1, ppn0=0xABCDE, mat0=1. LOAD va=0x00024123, asid 5 → after 2 cycles, pa=0xABCDE123, hit=1, idx=3, mat=1, excp=NONE.
- 2 MB page, odd half, global: entry 7 with ps=21, g=1, vppn[18:9]=0x004, ppn1=0x12300, v1=1. FETCH va=0x01234567, asid 9 → pa=0x12234567, idx=7.
- Exceptions:
  - Miss → TLBR, hit=0, pa=0.
  - Same 4 KB entry with v0=0: STORE → PIS.
  - d0=0, v0=1: STORE → PME.
  - Entry plv=0, req_plv=3 → PPI.
- Stalls and ordering: 4 back-to-back requests with resp_ready low for 3 cycles mid-stream → all 4 responses in order, none lost or duplicated, req_ready low while both stages are full.
- Flush and write isolation:
  - Flush with both stages full → no response appears.
  - A write to entry 3 one cycle after acceptance → the response still reflects the old entry.
- Multi-hit: entries 2 and 5 both match → idx=2, and resp_multi_hit=1 when TLB_MULTI_HIT_CHECK_EN is defined.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU definitions: TLB entry layout, op and exception codes
package cpu_defs;

  localparam int TLB_ENTRY_NUM = 16;
  localparam int TLB_IDX_WID   = $clog2(TLB_ENTRY_NUM);

  // Page size encodings held in the entry ps field
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  // One half (even/odd page) of an entry
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic        e;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } tlb_op_t;

  typedef enum logic [2:0] {
    EXCP_NONE = 3'd0,
    EXCP_TLBR = 3'd1,
    EXCP_PIF  = 3'd2,
    EXCP_PIL  = 3'd3,
    EXCP_PIS  = 3'd4,
    EXCP_PPI  = 3'd5,
    EXCP_PME  = 3'd6
  } tlb_excp_t;

  // Page-invalid exception flavour depends on the access kind
  function automatic tlb_excp_t invalid_excp(tlb_op_t op);
    case (op)
      OP_FETCH: return EXCP_PIF;
      OP_LOAD:  return EXCP_PIL;
      default:  return EXCP_PIS;
    endcase
  endfunction

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - parallel entry compare and lowest-index priority encoder (shared with TLBSRCH)
module tlb_match
  import cpu_defs::*;
(
  input  tlb_entry_t              i_entries [TLB_ENTRY_NUM],
  input  logic [18:0]             i_va_tag,
  input  logic [9:0]              i_asid,
  output logic [TLB_ENTRY_NUM-1:0] o_hit_vec,
  output logic [TLB_IDX_WID-1:0]  o_hit_idx,
  output tlb_entry_t              o_hit_entry
);

  // Per-entry match: enabled, ASID or global, and VPN compare at the entry's page size
  always_comb begin
    o_hit_vec = '0;
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      o_hit_vec[i] = i_entries[i].e
                  && (i_entries[i].g || (i_entries[i].asid == i_asid))
                  && ((i_entries[i].ps == PS_2M)
                      ? (i_entries[i].vppn[18:9] == i_va_tag[18:9])
                      : (i_entries[i].vppn == i_va_tag));
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing
  always_comb begin
    o_hit_idx   = '0;
    o_hit_entry = '0;
    for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
      if (o_hit_vec[i]) begin
        o_hit_idx   = i[TLB_IDX_WID-1:0];
        o_hit_entry = i_entries[i];
      end
    end
  end

endmodule

// File: rtl/tlb_lookup.sv
// rtl/tlb_lookup.sv - two-stage TLB translation port; TLB_MULTI_HIT_CHECK_EN adds resp_multi_hit
module tlb_lookup
  import cpu_defs::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  tlb_entry_t             entries [TLB_ENTRY_NUM],
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_va,
  input  logic [9:0]             req_asid,
  input  logic [1:0]             req_plv,
  input  tlb_op_t                req_op,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_pa,
  output logic [1:0]             resp_mat,
  output logic                   resp_hit,
  output logic [TLB_IDX_WID-1:0] resp_idx,
  output tlb_excp_t              resp_excp
`ifdef TLB_MULTI_HIT_CHECK_EN
  ,
  output logic                   resp_multi_hit
`endif
);

  logic [TLB_ENTRY_NUM-1:0] w_hit_vec;
  logic [TLB_IDX_WID-1:0]   w_hit_idx;
  tlb_entry_t               w_hit_entry;
  logic                     w_unused_tag;
  logic                     w_s2_load;
  logic                     w_accept;

  logic                     r_s1_valid;
  logic [21:0]              r_s1_va;
  logic [1:0]               r_s1_plv;
  tlb_op_t                  r_s1_op;
  logic [TLB_ENTRY_NUM-1:0] r_s1_hit_vec;
  logic [TLB_IDX_WID-1:0]   r_s1_idx;
  logic [5:0]               r_s1_ps;
  tlb_page_t                r_s1_p0;
  tlb_page_t                r_s1_p1;

  logic                     r_s2_valid;
  logic [31:0]              r_resp_pa;
  logic [1:0]               r_resp_mat;
  logic                     r_resp_hit;
  logic [TLB_IDX_WID-1:0]   r_resp_idx;
  tlb_excp_t                r_resp_excp;

  logic                     w_odd;
  tlb_page_t                w_page;
  logic                     w_hit;
  logic [31:0]              w_pa;
  logic [1:0]               w_mat;
  tlb_excp_t                w_excp;

  tlb_match u_match (
    .i_entries   (entries),
    .i_va_tag    (req_va[31:13]),
    .i_asid      (req_asid),
    .o_hit_vec   (w_hit_vec),
    .o_hit_idx   (w_hit_idx),
    .o_hit_entry (w_hit_entry)
  );

  // Tag fields have done their job in the compare; stage 1 keeps only what translation needs
  assign w_unused_tag = ^{w_hit_entry.e, w_hit_entry.asid, w_hit_entry.g, w_hit_entry.vppn};

  assign w_s2_load = !r_s2_valid || resp_ready;
  assign req_ready = !flush && !rst && (!r_s1_valid || w_s2_load);
  assign w_accept  = req_valid && req_ready;

  // Pipeline occupancy; flush and reset empty both stages
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  // Stage 1 snapshots the winning entry so later array writes cannot disturb this request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_va      <= '0;
      r_s1_plv     <= '0;
      r_s1_op      <= OP_FETCH;
      r_s1_hit_vec <= '0;
      r_s1_idx     <= '0;
      r_s1_ps      <= '0;
      r_s1_p0      <= '0;
      r_s1_p1      <= '0;
    end else if (w_accept) begin
      r_s1_va      <= req_va[21:0];
      r_s1_plv     <= req_plv;
      r_s1_op      <= req_op;
      r_s1_hit_vec <= w_hit_vec;
      r_s1_idx     <= w_hit_idx;
      r_s1_ps      <= w_hit_entry.ps;
      r_s1_p0      <= w_hit_entry.p0;
      r_s1_p1      <= w_hit_entry.p1;
    end
  end

  assign w_odd  = (r_s1_ps == PS_2M) ? r_s1_va[21] : r_s1_va[12];
  assign w_page = w_odd ? r_s1_p1 : r_s1_p0;
  assign w_hit  = |r_s1_hit_vec;

  // Address formation and exception priority: miss, invalid, privilege, dirty
  always_comb begin
    w_pa   = '0;
    w_mat  = '0;
    w_excp = EXCP_NONE;
    if (!w_hit) begin
      w_excp = EXCP_TLBR;
    end else begin
      w_pa  = (r_s1_ps == PS_2M) ? {w_page.ppn[19:9], r_s1_va[20:0]}
                                 : {w_page.ppn, r_s1_va[11:0]};
      w_mat = w_page.mat;
      if (!w_page.v) begin
        w_excp = invalid_excp(r_s1_op);
      end else if (r_s1_plv > w_page.plv) begin
        w_excp = EXCP_PPI;
      end else if ((r_s1_op == OP_STORE) && !w_page.d) begin
        w_excp = EXCP_PME;
      end
    end
  end

  // Stage 2 result registers; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_pa   <= '0;
      r_resp_mat  <= '0;
      r_resp_hit  <= 1'b0;
      r_resp_idx  <= '0;
      r_resp_excp <= EXCP_NONE;
    end else if (w_s2_load && r_s1_valid && !flush) begin
      r_resp_pa   <= w_pa;
      r_resp_mat  <= w_mat;
      r_resp_hit  <= w_hit;
      r_resp_idx  <= r_s1_idx;
      r_resp_excp <= w_excp;
    end
  end

  assign resp_valid = r_s2_valid;
  assign resp_pa    = r_resp_pa;
  assign resp_mat   = r_resp_mat;
  assign resp_hit   = r_resp_hit;
  assign resp_idx   = r_resp_idx;
  assign resp_excp  = r_resp_excp;

`ifdef TLB_MULTI_HIT_CHECK_EN
  logic w_multi;
  logic r_s1_multi;
  logic r_resp_multi;

  // Clearing the lowest set bit leaves something only when two or more entries matched
  assign w_multi = |(w_hit_vec & (w_hit_vec - TLB_ENTRY_NUM'(1)));

  // Multi-hit flag rides alongside the normal stage 1 / stage 2 data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_multi   <= 1'b0;
      r_resp_multi <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_multi <= w_multi;
      end
      if (w_s2_load && r_s1_valid && !flush) begin
        r_resp_multi <= r_s1_multi;
      end
    end
  end

  assign resp_multi_hit = r_resp_multi;
`endif

endmodule
